fb_writer: RTL and testbench

//  Write side of the SRAM framebuffer scanned out by the display stage. Accepts
//  (x,y,pixel) writes from the renderer over valid/ready and performs half-word

---
 rtl/fb_writer_if.sv | 29 ++
 rtl/fb_writer.sv | 106 ++++++++++
 tb/tb_fb_writer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fb_writer_if.sv
// Renderer pixel stream, clear control, display-read arbitration and SRAM write
// port of the framebuffer writer.
interface fb_writer_if #(
  parameter int ADDR_W = 19
);
  logic              px_valid;
  logic              px_ready;
  logic [9:0]        px_x;
  logic [9:0]        px_y;
  logic [15:0]       px_data;
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;
  logic              disp_read;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_waddr;
  logic [31:0]       sram_wdata;
  logic [3:0]        sram_be;

  modport slave (
    input  px_valid, px_x, px_y, px_data, clear_req, disp_read,
    output px_ready, clear_busy, clear_done, sram_we, sram_waddr, sram_wdata, sram_be
  );

  modport master (
    output px_valid, px_x, px_y, px_data, clear_req, disp_read,
    input  px_ready, clear_busy, clear_done, sram_we, sram_waddr, sram_wdata, sram_be
  );
endinterface

// File: rtl/fb_writer.sv
// Framebuffer write side: one-entry pixel hold register feeding half-word SRAM
// writes, plus a zero-fill sequencer; display reads always win the SRAM port.
module fb_writer #(
  parameter int FB_W   = 600,
  parameter int FB_H   = 600,
  parameter int ADDR_W = 19
) (
  input logic        clk,
  input logic        rst,
  fb_writer_if.slave bus
);

  localparam int                WORDS     = FB_W * FB_H / 2;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [9:0]        FB_W_L    = 10'(FB_W);
  localparam logic [9:0]        FB_H_L    = 10'(FB_H);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              clr_we, busy, done;

  logic [ADDR_W:0]   lin_p0;
  logic              in_range_p0;
  logic              accept_p0;
  logic              vld_p1, vld_nxt;
  logic [ADDR_W-1:0] addr_p1;
  logic [15:0]       data_p1;
  logic              hi_p1;
  logic              retire;

  // ---- stage p0: address computation at accept ----
  assign lin_p0      = (ADDR_W+1)'(bus.px_y) * (ADDR_W+1)'(FB_W)
                     + (ADDR_W+1)'(bus.px_x);
  assign in_range_p0 = (bus.px_x < FB_W_L) && (bus.px_y < FB_H_L);

  assign retire       = vld_p1 && !bus.disp_read && !rst;
  assign bus.px_ready = !rst && (state == IDLE) && (!vld_p1 || retire);
  assign accept_p0    = bus.px_valid && bus.px_ready;
  // Out-of-range pixels are consumed without ever occupying the hold register.
  assign vld_nxt      = (accept_p0 && in_range_p0) || (vld_p1 && !retire);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (bus.clear_req) state_nxt = vld_nxt ? DRAIN : CLEAR;
      DRAIN: if (!vld_nxt) state_nxt = CLEAR;
      CLEAR: begin
        busy = 1'b1;
        if (!bus.disp_read) begin
          clr_we = 1'b1;
          if (cnt == LAST_WORD) begin
            busy      = 1'b0;
            done      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      clr_we = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      vld_p1 <= vld_nxt;
    end
  end

  // ---- stage p1: hold register, stable for the whole disp_read stall ----
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      addr_p1 <= lin_p0[ADDR_W:1];
      hi_p1   <= lin_p0[0];
      data_p1 <= bus.px_data;
    end
  end

  assign bus.sram_we    = retire || clr_we;
  assign bus.sram_waddr = (state == CLEAR) ? cnt :
                          (vld_p1 ? addr_p1 : '0);
  assign bus.sram_wdata = (state != CLEAR && vld_p1) ? {data_p1, data_p1} : 32'h0;
  assign bus.sram_be    = clr_we ? 4'hF :
                          retire ? (hi_p1 ? 4'b1100 : 4'b0011) : 4'h0;
  assign bus.clear_busy = busy;
  assign bus.clear_done = done;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: a 600x600 instance for pixel/reset behaviour and
// a 20x10 instance to run complete clear sequences in few cycles.
module tb_fb_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fb_writer_if #(.ADDR_W(19)) b ();
  fb_writer_if #(.ADDR_W(19)) s ();

  fb_writer #(.FB_W(600), .FB_H(600), .ADDR_W(19)) u_big (
    .clk(clk), .rst(rst), .bus(b.slave));
  fb_writer #(.FB_W(20), .FB_H(10), .ADDR_W(19)) u_small (
    .clk(clk), .rst(rst), .bus(s.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_big(input string tag, input logic we, input logic [18:0] wa,
                         input logic [3:0] be, input logic [31:0] wd);
    chk({tag, "_we"}, 32'(b.sram_we), 32'(we));
    chk({tag, "_waddr"}, 32'(b.sram_waddr), 32'(wa));
    chk({tag, "_be"}, 32'(b.sram_be), 32'(be));
    chk({tag, "_wdata"}, b.sram_wdata, wd);
  endtask

  initial begin
    int nw;
    int dones;
    bit found;
    b.px_valid = 0; b.px_x = 0; b.px_y = 0; b.px_data = 0; b.clear_req = 0; b.disp_read = 0;
    s.px_valid = 0; s.px_x = 0; s.px_y = 0; s.px_data = 0; s.clear_req = 0; s.disp_read = 0;

    // Reset cycle and first cycle after it
    cyc();
    #1;
    chk_big("rst", 1'b0, 19'd0, 4'h0, 32'h0);
    chk("rst_ready", 32'(b.px_ready), 32'd0);
    chk("rst_busy", 32'(b.clear_busy), 32'd0);
    chk("rst_done", 32'(b.clear_done), 32'd0);
    rst = 0;
    #1;
    chk("post_rst_ready", 32'(b.px_ready), 32'd1);

    // Pixel (0,0) -> word 0, low half
    b.px_valid = 1; b.px_x = 0; b.px_y = 0; b.px_data = 16'h01FF;
    cyc();
    b.px_x = 599; b.px_y = 599; b.px_data = 16'h0180;
    #1;
    chk_big("px00", 1'b1, 19'd0, 4'b0011, 32'h01FF01FF);
    chk("px00_ready", 32'(b.px_ready), 32'd1);

    // Pixel (599,599) -> lin 359999, word 179999, high half
    cyc();
    b.px_valid = 0;
    #1;
    chk_big("px599", 1'b1, 19'd179999, 4'b1100, 32'h01800180);
    cyc();
    #1;
    chk("idle_we", 32'(b.sram_we), 32'd0);

    // Stall: pixel (10,1) -> lin 610, word 305 low; held under disp_read
    b.disp_read = 1; b.px_valid = 1; b.px_x = 10; b.px_y = 1; b.px_data = 16'h1234;
    cyc();
    b.px_x = 11; b.px_data = 16'h00AB;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_we", 32'(b.sram_we), 32'd0);
      chk("stall_be", 32'(b.sram_be), 32'd0);
      chk("stall_ready", 32'(b.px_ready), 32'd0);
      chk("stall_waddr", 32'(b.sram_waddr), 32'd305);
      chk("stall_wdata", b.sram_wdata, 32'h12341234);
      cyc();
    end
    b.disp_read = 0;
    #1;
    chk_big("stall_rel", 1'b1, 19'd305, 4'b0011, 32'h12341234);
    chk("stall_rel_ready", 32'(b.px_ready), 32'd1);
    cyc();
    b.px_valid = 0;
    #1;
    chk_big("px11_1", 1'b1, 19'd305, 4'b1100, 32'h00AB00AB);
    cyc();
    #1;
    chk("after_px11_we", 32'(b.sram_we), 32'd0);

    // Out-of-range pixels: accepted, never written
    b.px_valid = 1; b.px_x = 600; b.px_y = 5;
    #1;
    chk("oor1_ready", 32'(b.px_ready), 32'd1);
    cyc();
    b.px_x = 3; b.px_y = 600;
    #1;
    chk("oor1_we", 32'(b.sram_we), 32'd0);
    chk("oor2_ready", 32'(b.px_ready), 32'd1);
    cyc();
    b.px_valid = 0;
    #1;
    chk("oor2_we", 32'(b.sram_we), 32'd0);
    chk("oor2_be", 32'(b.sram_be), 32'd0);

    // Small instance: clear with disp_read toggling, a second request mid-clear
    s.clear_req = 1;
    cyc();
    s.clear_req = 0;
    nw = 0; dones = 0;
    for (int k = 0; k < 260; k++) begin
      s.disp_read = k[0];
      s.clear_req = (k == 40);
      #1;
      if (k == 10) begin
        chk("clr_busy", 32'(s.clear_busy), 32'd1);
        chk("clr_ready", 32'(s.px_ready), 32'd0);
      end
      if (s.sram_we) begin
        chk("clr_no_disp", 32'(s.disp_read), 32'd0);
        chk("clr_addr", 32'(s.sram_waddr), 32'(nw));
        chk("clr_be", 32'(s.sram_be), 32'hF);
        chk("clr_wdata", s.sram_wdata, 32'h0);
        nw++;
      end
      if (s.clear_done) begin
        dones++;
        chk("clr_done_at_last", 32'(nw), 32'd100);
        chk("clr_done_busy", 32'(s.clear_busy), 32'd0);
      end
      cyc();
    end
    s.clear_req = 0; s.disp_read = 0;
    #1;
    chk("clr_writes", 32'(nw), 32'd100);
    chk("clr_dones", 32'(dones), 32'd1);
    chk("clr_end_busy", 32'(s.clear_busy), 32'd0);
    chk("clr_end_ready", 32'(s.px_ready), 32'd1);

    // Small instance: pixel coincident with clear_req is written first
    s.px_valid = 1; s.px_x = 1; s.px_y = 0; s.px_data = 16'h0155; s.clear_req = 1;
    cyc();
    s.px_valid = 0; s.clear_req = 0;
    #1;
    chk("co_we", 32'(s.sram_we), 32'd1);
    chk("co_addr", 32'(s.sram_waddr), 32'd0);
    chk("co_be", 32'(s.sram_be), 32'b1100);
    chk("co_wdata", s.sram_wdata, 32'h01550155);
    chk("co_ready", 32'(s.px_ready), 32'd0);
    cyc();
    #1;
    chk("co_clr_be", 32'(s.sram_be), 32'hF);
    chk("co_clr_addr", 32'(s.sram_waddr), 32'd0);
    dones = 0;
    for (int k = 0; k < 200 && dones == 0; k++) begin
      if (s.clear_done) dones++;
      cyc();
    end
    chk("co_clr_done", 32'(dones), 32'd1);

    // Big instance: reset while clear is at word 1000
    b.clear_req = 1;
    cyc();
    b.clear_req = 0;
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      #1;
      if (b.sram_we && b.sram_waddr == 19'd1000) begin
        found = 1;
        break;
      end
      cyc();
    end
    chk("clr1000_reached", 32'(found), 32'd1);
    rst = 1;
    cyc();
    #1;
    chk_big("midclr_rst", 1'b0, 19'd0, 4'h0, 32'h0);
    chk("midclr_busy", 32'(b.clear_busy), 32'd0);
    chk("midclr_done", 32'(b.clear_done), 32'd0);
    chk("midclr_ready", 32'(b.px_ready), 32'd0);
    rst = 0;
    #1;
    chk("midclr_ready_after", 32'(b.px_ready), 32'd1);
    // Pixel (5,2) -> lin 1205, word 602 high half
    b.px_valid = 1; b.px_x = 5; b.px_y = 2; b.px_data = 16'h00FF;
    cyc();
    b.px_valid = 0;
    #1;
    chk_big("post_rst_px", 1'b1, 19'd602, 4'b1100, 32'h00FF00FF);
    chk("post_rst_busy", 32'(b.clear_busy), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  // Port invariants on both instances, every cycle
  always @(negedge clk) begin
    if (!rst) begin
      if ((b.sram_we && b.disp_read) || (!b.sram_we && b.sram_be != 4'h0)) begin
        total++; fails++;
        $error("FAIL big_invariant: we=%0b disp=%0b be=%0h required no write under disp_read and be=0 when idle",
               b.sram_we, b.disp_read, b.sram_be);
      end
      if ((s.sram_we && s.disp_read) || (!s.sram_we && s.sram_be != 4'h0)) begin
        total++; fails++;
        $error("FAIL small_invariant: we=%0b disp=%0b be=%0h required no write under disp_read and be=0 when idle",
               s.sram_we, s.disp_read, s.sram_be);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
